// File: rtl/branch_resolution_buffer_pkg.sv
// Shared definitions for the branch resolution buffer.
// ROB index width, drain length and FSM state encodings.
package branch_resolution_buffer_pkg;

    localparam int BRB_ROB_IDX_W    = 4;
    localparam int BRB_DRAIN_CYCLES = 2;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } brb_state_e;

endpackage

// File: rtl/brb_entry.sv
// Single ROB-index branch record: pending/resolved flags,
// predicted and actual direction, resolved next-PC.
module brb_entry (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        alloc,
    input  logic        alloc_pred,
    input  logic        result,
    input  logic        res_taken,
    input  logic [31:0] res_pc,
    input  logic        clear,
    output logic        pending,
    output logic        resolved,
    output logic        pred,
    output logic        taken,
    output logic [31:0] pc
);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending  <= 1'b0;
            resolved <= 1'b0;
            pred     <= 1'b0;
            taken    <= 1'b0;
            pc       <= '0;
        end else if (clear) begin
            pending  <= 1'b0;
            resolved <= 1'b0;
        end else if (alloc) begin
            pending  <= 1'b1;
            resolved <= 1'b0;
            pred     <= alloc_pred;
        end else if (result) begin
            resolved <= 1'b1;
            taken    <= res_taken;
            pc       <= res_pc;
        end
    end

endmodule

// File: rtl/branch_resolution_buffer.sv
// Resolved-branch receiver: commit ack or mispredict flush + drain.
// Optional BRB_STATS_EN adds commit/mispredict counters.
module branch_resolution_buffer
    import branch_resolution_buffer_pkg::*;
#(
    parameter int ROB_IDX_W    = BRB_ROB_IDX_W,
    parameter int DRAIN_CYCLES = BRB_DRAIN_CYCLES
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 alloc_valid,
    input  logic [ROB_IDX_W-1:0] alloc_rob_id,
    input  logic                 alloc_pred,
    input  logic [ROB_IDX_W-1:0] res_rob_id,
    input  logic                 res_taken,
    input  logic [31:0]          res_value,
    input  logic                 commit_valid,
    input  logic [ROB_IDX_W-1:0] commit_rob_id,
`ifdef BRB_STATS_EN
    output logic [31:0]          stat_commits,
    output logic [31:0]          stat_mispredicts,
`endif
    output logic                 commit_ack,
    output logic                 flush_out,
    output logic [31:0]          redirect_pc,
    output logic                 busy_drain
);

    localparam int N     = 1 << ROB_IDX_W;
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    brb_state_e       state, state_nxt;
    logic [CNT_W-1:0] drain_cnt, cnt_nxt;

    logic [N-1:0] pending, resolved, pred, taken;
    logic [31:0]  pc [N];

    logic        run, alloc_en, res_ok, c_byp, c_fire;
    logic        c_taken, c_hit, c_miss;
    logic [31:0] c_pc;

    assign run      = (state == RUN);
    assign alloc_en = run && alloc_valid && (alloc_rob_id != '0);

    // Same-cycle alloc to the result's id takes priority over the result.
    assign res_ok = run && (res_rob_id != '0) && pending[res_rob_id]
                    && !(alloc_en && alloc_rob_id == res_rob_id);

    assign c_byp  = res_ok && (res_rob_id == commit_rob_id);
    assign c_fire = run && commit_valid && (commit_rob_id != '0)
                    && pending[commit_rob_id]
                    && (resolved[commit_rob_id] || c_byp);

    assign c_taken = c_byp ? res_taken : taken[commit_rob_id];
    assign c_pc    = c_byp ? res_value : pc[commit_rob_id];
    assign c_hit   = c_fire && (c_taken == pred[commit_rob_id]);
    assign c_miss  = c_fire && (c_taken != pred[commit_rob_id]);

    assign pending[0]  = 1'b0;
    assign resolved[0] = 1'b0;
    assign pred[0]     = 1'b0;
    assign taken[0]    = 1'b0;
    assign pc[0]       = '0;

    for (genvar i = 1; i < N; i++) begin : g_entry
        logic a_i, r_i, clr_i;

        assign a_i   = alloc_en && (alloc_rob_id == ROB_IDX_W'(i));
        assign r_i   = res_ok && (res_rob_id == ROB_IDX_W'(i));
        assign clr_i = c_miss
                       || (c_hit && commit_rob_id == ROB_IDX_W'(i) && !a_i);

        brb_entry u_entry (
            .clk_in     (clk_in),
            .rst_n_in   (rst_n_in),
            .alloc      (a_i),
            .alloc_pred (alloc_pred),
            .result     (r_i),
            .res_taken  (res_taken),
            .res_pc     (res_value),
            .clear      (clr_i),
            .pending    (pending[i]),
            .resolved   (resolved[i]),
            .pred       (pred[i]),
            .taken      (taken[i]),
            .pc         (pc[i])
        );
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = drain_cnt;
        unique case (state)
            RUN: begin
                if (c_miss) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = drain_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            commit_ack  <= 1'b0;
            flush_out   <= 1'b0;
            redirect_pc <= '0;
        end else begin
            commit_ack <= c_hit;
            flush_out  <= c_miss;
            if (c_miss) begin
                redirect_pc <= c_pc;
            end
        end
    end

    assign busy_drain = (state == DRAIN);

`ifdef BRB_STATS_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_commits     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (c_fire) begin
                stat_commits <= stat_commits + 32'd1;
            end
            if (c_miss) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolution_buffer.sv
// Self-checking bench for branch_resolution_buffer (directed + random
// against a reference model; stats checked when BRB_STATS_EN is defined).
module tb_branch_resolution_buffer;

    localparam int W  = 4;
    localparam int NE = 16;
    localparam int DC = 2;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         alloc_valid;
    logic [W-1:0] alloc_rob_id;
    logic         alloc_pred;
    logic [W-1:0] res_rob_id;
    logic         res_taken;
    logic [31:0]  res_value;
    logic         commit_valid;
    logic [W-1:0] commit_rob_id;
    logic         commit_ack;
    logic         flush_out;
    logic [31:0]  redirect_pc;
    logic         busy_drain;
`ifdef BRB_STATS_EN
    logic [31:0]  stat_commits;
    logic [31:0]  stat_mispredicts;
`endif

    branch_resolution_buffer dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .alloc_valid      (alloc_valid),
        .alloc_rob_id     (alloc_rob_id),
        .alloc_pred       (alloc_pred),
        .res_rob_id       (res_rob_id),
        .res_taken        (res_taken),
        .res_value        (res_value),
        .commit_valid     (commit_valid),
        .commit_rob_id    (commit_rob_id),
`ifdef BRB_STATS_EN
        .stat_commits     (stat_commits),
        .stat_mispredicts (stat_mispredicts),
`endif
        .commit_ack       (commit_ack),
        .flush_out        (flush_out),
        .redirect_pc      (redirect_pc),
        .busy_drain       (busy_drain)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: what the ROB-side buffer should know about each id.
    bit          m_pend [NE];
    bit          m_res  [NE];
    bit          m_pred [NE];
    bit          m_tkn  [NE];
    bit [31:0]   m_pc   [NE];
    int          m_drain;
    bit          e_ack, e_flush;
    bit [31:0]   e_pc;
    int unsigned e_sc, e_sm;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_pend[i] = 0; m_res[i] = 0; m_pred[i] = 0;
            m_tkn[i]  = 0; m_pc[i]  = 0;
        end
        m_drain = 0; e_ack = 0; e_flush = 0; e_pc = 0;
        e_sc = 0; e_sm = 0;
    endtask

    // One clock edge of the intended behaviour, from the sampled inputs.
    task automatic model_edge();
        bit a, r, fire, t, p_old;
        bit [31:0] p;
        int ai, ri, ci;
        ai = int'(alloc_rob_id);
        ri = int'(res_rob_id);
        ci = int'(commit_rob_id);
        e_ack = 0; e_flush = 0;
        if (m_drain > 0) begin
            m_drain--;
            return;
        end
        a = alloc_valid && ai != 0;
        r = ri != 0 && m_pend[ri] && !(a && ai == ri);
        fire = 0; t = 0; p = 0;
        p_old = m_pred[ci];
        if (commit_valid && ci != 0 && m_pend[ci]) begin
            if (r && ri == ci) begin
                fire = 1; t = res_taken; p = res_value;
            end else if (m_res[ci]) begin
                fire = 1; t = m_tkn[ci]; p = m_pc[ci];
            end
        end
        if (r) begin
            m_res[ri] = 1; m_tkn[ri] = res_taken; m_pc[ri] = res_value;
        end
        if (a) begin
            m_pend[ai] = 1; m_res[ai] = 0; m_pred[ai] = alloc_pred;
        end
        if (fire) begin
            e_sc++;
            if (t == p_old) begin
                e_ack = 1;
                if (!(a && ai == ci)) begin
                    m_pend[ci] = 0; m_res[ci] = 0;
                end
            end else begin
                e_flush = 1; e_pc = p; e_sm++;
                m_drain = DC;
                for (int i = 0; i < NE; i++) begin
                    m_pend[i] = 0; m_res[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ack"},   32'(commit_ack), 32'(e_ack));
        chk({tag, ".flush"}, 32'(flush_out),  32'(e_flush));
        chk({tag, ".pc"},    redirect_pc,     e_pc);
        chk({tag, ".busy"},  32'(busy_drain), 32'(m_drain > 0));
`ifdef BRB_STATS_EN
        chk({tag, ".sc"},    stat_commits,     e_sc);
        chk({tag, ".sm"},    stat_mispredicts, e_sm);
`endif
    endtask

    task automatic drive(input bit av, input int aid, input bit ap,
                         input int rid, input bit rt, input bit [31:0] rv,
                         input bit cv, input int cid);
        alloc_valid   = av;
        alloc_rob_id  = W'(aid);
        alloc_pred    = ap;
        res_rob_id    = W'(rid);
        res_taken     = rt;
        res_value     = rv;
        commit_valid  = cv;
        commit_rob_id = W'(cid);
    endtask

    task automatic step(input string tag);
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_all(tag);
    endtask

    initial begin
        rst_n_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step("idle");

        // Correct prediction, resolved ahead of commit.
        drive(1, 3, 0, 0, 0, 0, 0, 0); step("a3");
        drive(0, 0, 0, 3, 0, 32'h104, 0, 0); step("r3");
        drive(0, 0, 0, 0, 0, 0, 1, 3); step("c3");
        chk("t1_ack", 32'(commit_ack), 32'd1);
        chk("t1_flush", 32'(flush_out), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("t1_idle");
        chk("t1_ack_drop", 32'(commit_ack), 32'd0);

        // Mispredict, then drain ignores a dispatch.
        drive(1, 5, 0, 0, 0, 0, 0, 0); step("a5");
        drive(0, 0, 0, 5, 1, 32'h200, 0, 0); step("r5");
        drive(0, 0, 0, 0, 0, 0, 1, 5); step("c5");
        chk("t2_flush", 32'(flush_out), 32'd1);
        chk("t2_redir", redirect_pc, 32'h200);
        chk("t2_busy0", 32'(busy_drain), 32'd1);
        drive(1, 6, 0, 0, 0, 0, 0, 0); step("d1");
        chk("t2_busy1", 32'(busy_drain), 32'd1);
        chk("t2_flush_drop", 32'(flush_out), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step("d2");
        chk("t2_run", 32'(busy_drain), 32'd0);
        chk("t2_pc_hold", redirect_pc, 32'h200);
        drive(0, 0, 0, 6, 0, 32'h300, 1, 6); step("c6");
        chk("t2_no_ack", 32'(commit_ack), 32'd0);

        // Result bypass at commit.
        drive(1, 7, 1, 0, 0, 0, 0, 0); step("a7");
        drive(0, 0, 0, 7, 1, 32'h700, 1, 7); step("c7");
        chk("t3_bypass_ack", 32'(commit_ack), 32'd1);

        // Alloc beats result in the same cycle.
        drive(1, 2, 0, 2, 0, 32'h220, 0, 0); step("ar2");
        drive(0, 0, 0, 0, 0, 0, 1, 2); step("c2w");
        chk("t4_wait", 32'(commit_ack), 32'd0);
        drive(0, 0, 0, 2, 0, 32'h224, 1, 2); step("c2");
        chk("t4_ack", 32'(commit_ack), 32'd1);

        // Result to an unallocated id is dropped.
        drive(0, 0, 0, 9, 1, 32'h900, 0, 0); step("r9");
        drive(0, 0, 0, 0, 0, 0, 1, 9); step("c9");
        chk("t5_ack", 32'(commit_ack), 32'd0);
        chk("t5_flush", 32'(flush_out), 32'd0);
`ifdef BRB_STATS_EN
        chk("t6_commits", stat_commits, 32'd4);
        chk("t6_mispred", stat_mispredicts, 32'd1);
`endif

        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            step("rnd");
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step("settle");

        // Asynchronous reset in the middle of a drain.
        drive(1, 4, 1, 0, 0, 0, 0, 0); step("a4");
        drive(0, 0, 0, 4, 0, 32'h444, 1, 4); step("c4");
        chk("t7_flush", 32'(flush_out), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n_in = 1'b0;
        #1;
        model_reset();
        chk("t7_rst_flush", 32'(flush_out), 32'd0);
        chk("t7_rst_busy", 32'(busy_drain), 32'd0);
        chk("t7_rst_pc", redirect_pc, 32'd0);
        chk("t7_rst_ack", 32'(commit_ack), 32'd0);
`ifdef BRB_STATS_EN
        chk("t7_rst_sc", stat_commits, 32'd0);
        chk("t7_rst_sm", stat_mispredicts, 32'd0);
`endif
        @(negedge clk_in);
        rst_n_in = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 4); step("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
